id_ex_stage: RTL and testbench

// - ID/EX pipeline register of the 5-stage MIPS core; sits directly downstream of the main decoder.
// - Captures the decoder's control bundle plus ID operands each cycle.
// - Performs load-use hazard detection and inserts bubbles: zeroed control, PC and IF/ID held.
// - Supports flush on taken branch and a hold request from a later stage; counts inserted bubbles.

---
 rtl/id_ex_stage_pkg.sv | 27 ++
 rtl/id_ex_stage_hazard_detect.sv | 24 ++
 rtl/id_ex_stage.sv | 79 +++++++
 tb/tb_id_ex_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: control-bundle layout, ALU-op
// encodings and the bubble value.
package id_ex_stage_pkg;

    localparam int CTRL_W = 9;

    localparam int CTRL_BRANCH_EQ = 8;
    localparam int CTRL_ALUOP_HI  = 7;
    localparam int CTRL_ALUOP_LO  = 6;
    localparam int CTRL_MEMREAD   = 5;
    localparam int CTRL_MEMWRITE  = 4;
    localparam int CTRL_MEMTOREG  = 3;
    localparam int CTRL_REGDST    = 2;
    localparam int CTRL_REGWRITE  = 1;
    localparam int CTRL_ALUSRC    = 0;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 9'b0;

    function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction in ID stalls PC and IF/ID for one cycle.
module hazard_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  reset,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  hold,
    output logic                  load_use,
    output logic                  pc_write,
    output logic                  if_id_write
);

    // $0 is hard-wired zero, so a load targeting it never creates a dependency.
    always_comb begin
        load_use    = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        pc_write    = !(load_use || hold) && !reset;
        if_id_write = pc_write;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and a
// saturating count of inserted load-use bubbles.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic [DATA_W-1:0]     id_pc4,
    input  logic [DATA_W-1:0]     id_rd1,
    input  logic [DATA_W-1:0]     id_rd2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  flush,
    input  logic                  hold,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [DATA_W-1:0]     ex_pc4,
    output logic [DATA_W-1:0]     ex_rd1,
    output logic [DATA_W-1:0]     ex_rd2,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic [CNT_W-1:0]      bubble_cnt
);

    logic load_use;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .reset       (reset),
        .ex_memread  (ctrl_is_load(ex_ctrl)),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .hold        (hold),
        .load_use    (load_use),
        .pc_write    (pc_write),
        .if_id_write (if_id_write)
    );

    // Stage control: flush beats hold beats load-use. A flush or load-use
    // bubble still captures the ID data fields; only the control is zeroed.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl    <= CTRL_BUBBLE;
            ex_pc4     <= '0;
            ex_rd1     <= '0;
            ex_rd2     <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            bubble_cnt <= '0;
        end else if (!hold || flush) begin
            ex_ctrl <= (flush || load_use) ? CTRL_BUBBLE : id_ctrl;
            ex_pc4  <= id_pc4;
            ex_rd1  <= id_rd1;
            ex_rd2  <= id_rd2;
            ex_imm  <= id_imm;
            ex_rs   <= id_rs;
            ex_rt   <= id_rt;
            ex_rd   <= id_rd;
            if (!flush && load_use && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: two instances (16-bit and 2-bit bubble
// counters) share stimulus and are compared against a behavioural model.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic          pcw;
        logic          ifw;
        logic [8:0]    ctrl;
        logic [DW-1:0] pc4;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic [15:0]   cnt;
        logic [1:0]    cnt2;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [8:0] id_ctrl = '0;
    logic [DW-1:0] id_pc4 = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
    logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic flush = 1'b0, hold = 1'b0;

    logic [8:0] ex_ctrl, ex_ctrl2;
    logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [DW-1:0] ex_pc4_2, ex_rd1_2, ex_rd2_2, ex_imm_2;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd, ex_rs2, ex_rt2, ex_rd2b;
    logic pc_write, if_id_write, pc_write2, if_id_write2;
    logic [15:0] bubble_cnt;
    logic [1:0] bubble_cnt2;

    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    bit mon_busy = 1'b0;

    // model state
    logic [8:0] m_ctrl;
    logic [DW-1:0] m_pc4, m_rd1, m_rd2, m_imm;
    logic [AW-1:0] m_rs, m_rt, m_rd;
    int m_cnt, m_cnt2;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_pc4(id_pc4),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .hold(hold),
        .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .pc_write(pc_write), .if_id_write(if_id_write), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_pc4(id_pc4),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .hold(hold),
        .ex_ctrl(ex_ctrl2), .ex_pc4(ex_pc4_2), .ex_rd1(ex_rd1_2), .ex_rd2(ex_rd2_2),
        .ex_imm(ex_imm_2), .ex_rs(ex_rs2), .ex_rt(ex_rt2), .ex_rd(ex_rd2b),
        .pc_write(pc_write2), .if_id_write(if_id_write2), .bubble_cnt(bubble_cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of ID inputs and push the model's expected response.
    task automatic step(input logic rst, input logic [8:0] ctrl, input logic [AW-1:0] rs,
                        input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                        input logic fl, input logic hd);
        exp_t e;
        bit lu;
        @(posedge clk);
        #2;
        reset = rst; id_ctrl = ctrl; id_rs = rs; id_rt = rt; id_rd = rd;
        flush = fl; hold = hd;
        id_pc4 = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;

        lu = (m_ctrl[5] === 1'b1) && (m_rt != 0) && (m_rt == rs || m_rt == rt);
        e.pcw = !rst && !lu && !hd;
        e.ifw = e.pcw;
        if (rst) begin
            m_ctrl = '0; m_pc4 = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
            m_rs = '0; m_rt = '0; m_rd = '0; m_cnt = 0; m_cnt2 = 0;
        end else if (fl || !hd) begin
            m_ctrl = (fl || lu) ? 9'h000 : ctrl;
            m_pc4 = id_pc4; m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
            m_rs = rs; m_rt = rt; m_rd = rd;
            if (!fl && lu) begin
                m_cnt  = (m_cnt  < 65535) ? m_cnt + 1 : 65535;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
        end
        e.ctrl = m_ctrl; e.pc4 = m_pc4; e.rd1 = m_rd1; e.rd2 = m_rd2; e.imm = m_imm;
        e.rs = m_rs; e.rt = m_rt; e.rd = m_rd;
        e.cnt = 16'(m_cnt); e.cnt2 = 2'(m_cnt2);
        exp_q.push_back(EXP_W'(e));
    endtask

    // Monitor: combinational outputs mid-cycle, registered outputs after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_busy = 1'b1;
                e = exp_t'(exp_q.pop_front());
                check("pc_write", 32'(pc_write), 32'(e.pcw));
                check("if_id_write", 32'(if_id_write), 32'(e.ifw));
                check("pc_write_sat", 32'(pc_write2), 32'(e.pcw));
                @(posedge clk);
                #1;
                check("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
                check("ex_ctrl_sat", 32'(ex_ctrl2), 32'(e.ctrl));
                check("ex_pc4", ex_pc4, e.pc4);
                check("ex_rd1", ex_rd1, e.rd1);
                check("ex_rd2", ex_rd2, e.rd2);
                check("ex_imm", ex_imm, e.imm);
                check("ex_rs", 32'(ex_rs), 32'(e.rs));
                check("ex_rt", 32'(ex_rt), 32'(e.rt));
                check("ex_rd", 32'(ex_rd), 32'(e.rd));
                check("bubble_cnt", 32'(bubble_cnt), 32'(e.cnt));
                check("bubble_cnt_sat", 32'(bubble_cnt2), 32'(e.cnt2));
                mon_busy = 1'b0;
            end
        end
    end

    localparam logic [8:0] C_RTYPE = 9'b0_10_000_110;
    localparam logic [8:0] C_LW    = 9'b0_00_101_011;
    localparam logic [8:0] C_ADDI  = 9'b0_00_000_011;

    initial begin
        m_ctrl = 'x; m_rt = 'x;
        m_cnt = 0; m_cnt2 = 0;

        // reset with all-ones control on the input
        step(1, 9'h1FF, 1, 2, 3, 0, 0);
        step(1, 9'h1FF, 1, 2, 3, 0, 0);
        // pass-through R-type
        step(0, C_RTYPE, 1, 2, 3, 0, 0);
        step(0, C_RTYPE, 4, 6, 7, 0, 0);
        // load-use on $5, then the dependent instruction re-issues
        step(0, C_LW, 0, 5, 0, 0, 0);
        step(0, C_RTYPE, 5, 1, 9, 0, 0);
        step(0, C_RTYPE, 5, 1, 9, 0, 0);
        // load into $0 never stalls
        step(0, C_LW, 0, 0, 0, 0, 0);
        step(0, C_RTYPE, 0, 0, 8, 0, 0);
        // flush + hold + load_use together, then hold alone
        step(0, C_LW, 2, 5, 0, 0, 0);
        step(0, C_RTYPE, 5, 5, 1, 1, 1);
        step(0, C_ADDI, 3, 4, 0, 0, 0);
        repeat (3) step(0, C_RTYPE, 3, 4, 2, 0, 1);
        // five load-use bubbles saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            step(0, C_LW, 1, 6, 0, 0, 0);
            step(0, C_RTYPE, 7, 6, 2, 0, 0);
        end
        // reset while stalled
        step(0, C_LW, 1, 9, 0, 0, 0);
        step(1, C_RTYPE, 9, 2, 3, 0, 0);
        step(0, C_RTYPE, 9, 2, 3, 0, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [8:0] c;
            c = 9'($urandom_range(0, 511));
            c[5] = ($urandom_range(0, 1) == 1);
            step(($urandom_range(0, 49) == 0), c,
                 AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 31)),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
        end

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && (exp_q.size() > 0 || mon_busy); i++) @(posedge clk);
        #5;
        checks++;
        if (exp_q.size() > 0 || mon_busy) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
